// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, FunctionUnit
// opcodes and instruction field positions.
package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  localparam logic [3:0] FS_TSFA  = 4'b0000;
  localparam logic [3:0] FS_INC   = 4'b0001;
  localparam logic [3:0] FS_ADD   = 4'b0010;
  localparam logic [3:0] FS_ADDC  = 4'b0011;
  localparam logic [3:0] FS_ADDNB = 4'b0100;
  localparam logic [3:0] FS_SUB   = 4'b0101;
  localparam logic [3:0] FS_DEC   = 4'b0110;
  localparam logic [3:0] FS_TSFA2 = 4'b0111;
  localparam logic [3:0] FS_AND   = 4'b1000;
  localparam logic [3:0] FS_OR    = 4'b1001;
  localparam logic [3:0] FS_XOR   = 4'b1010;
  localparam logic [3:0] FS_NOT   = 4'b1011;
  localparam logic [3:0] FS_TSFB  = 4'b1100;
  localparam logic [3:0] FS_LAST  = 4'b1100;

  localparam int FS_MSB  = 15;
  localparam int FS_LSB  = 12;
  localparam int DA_MSB  = 11;
  localparam int DA_LSB  = 9;
  localparam int AA_MSB  = 8;
  localparam int AA_LSB  = 6;
  localparam int BA_MSB  = 5;
  localparam int BA_LSB  = 3;
  localparam int REP_MSB = 2;
  localparam int REP_LSB = 0;

  function automatic logic fs_legal(input logic [3:0] fs);
    return fs <= FS_LAST;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of instruction handshake, load/readback and FunctionUnit signals.
// master = instruction source / FunctionUnit side, slave = the sequencer.
interface alu_sequencer_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
);
  logic                  InstrValid;
  logic                  InstrReady;
  logic [15:0]           Instr;
  logic                  LoadEn;
  logic [REG_ADDR_W-1:0] LoadAddr;
  logic [DATA_W-1:0]     LoadData;
  logic [REG_ADDR_W-1:0] ReadAddr;
  logic [DATA_W-1:0]     ReadData;
  logic [DATA_W-1:0]     AluA;
  logic [DATA_W-1:0]     AluB;
  logic [3:0]            AluFS;
  logic [DATA_W-1:0]     AluResult;
  logic                  Done;
  logic                  Error;
  logic                  ZeroFlag;
  logic                  NegFlag;

  modport master (
    output InstrValid, Instr, LoadEn, LoadAddr, LoadData, ReadAddr, AluResult,
    input  InstrReady, ReadData, AluA, AluB, AluFS, Done, Error, ZeroFlag, NegFlag
  );

  modport slave (
    input  InstrValid, Instr, LoadEn, LoadAddr, LoadData, ReadAddr, AluResult,
    output InstrReady, ReadData, AluA, AluB, AluFS, Done, Error, ZeroFlag, NegFlag
  );
endinterface

// File: rtl/alu_sequencer_regfile.sv
// REG_COUNT x DATA_W register file: one write port, three combinational read
// ports (operand A, operand B, external readback), async clear.
module alu_sequencer_regfile #(
  parameter int DATA_W     = 16,
  parameter int REG_COUNT  = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [REG_ADDR_W-1:0] ra_addr_i,
  output logic [DATA_W-1:0]     ra_data_o,
  input  logic [REG_ADDR_W-1:0] rb_addr_i,
  output logic [DATA_W-1:0]     rb_data_o,
  input  logic [REG_ADDR_W-1:0] rr_addr_i,
  output logic [DATA_W-1:0]     rr_data_o
);

  logic [DATA_W-1:0] mem_q [REG_COUNT];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o = mem_q[ra_addr_i];
  assign rb_data_o = mem_q[rb_addr_i];
  assign rr_data_o = mem_q[rr_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller sequencing an external FunctionUnit over an 8x16
// register file. Define ALU_SEQ_FLAGS_EN to register Zero/Neg result flags.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_COUNT  = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic           Clk,
  input  logic           Rst_n,
  alu_sequencer_if.slave bus
);

  state_e                state_q;
  logic [3:0]            fs_q;
  logic [REG_ADDR_W-1:0] da_q;
  logic [REG_ADDR_W-1:0] ba_q;
  logic [2:0]            cnt_q;
  logic [DATA_W-1:0]     res_q;
  logic [DATA_W-1:0]     alua_q;
  logic [DATA_W-1:0]     alub_q;
  logic [3:0]            alufs_q;
  logic                  done_q;
  logic                  err_q;

  logic [3:0]            instr_fs;
  logic [REG_ADDR_W-1:0] instr_da;
  logic [REG_ADDR_W-1:0] instr_aa;
  logic [REG_ADDR_W-1:0] instr_ba;
  logic [2:0]            instr_rep;
  logic                  ready;
  logic                  accept;
  logic                  we;
  logic [REG_ADDR_W-1:0] waddr;
  logic [DATA_W-1:0]     wdata;
  logic [REG_ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0]     rd_a;
  logic [DATA_W-1:0]     rd_b;

  assign instr_fs  = bus.Instr[FS_MSB:FS_LSB];
  assign instr_da  = bus.Instr[DA_MSB:DA_LSB];
  assign instr_aa  = bus.Instr[AA_MSB:AA_LSB];
  assign instr_ba  = bus.Instr[BA_MSB:BA_LSB];
  assign instr_rep = bus.Instr[REP_MSB:REP_LSB];

  assign ready  = (state_q == ST_IDLE) && !bus.LoadEn;
  assign accept = bus.InstrValid && ready;

  // External loads only land in IDLE; write-back owns the port in WB.
  assign we      = ((state_q == ST_IDLE) && bus.LoadEn) || (state_q == ST_WB);
  assign waddr   = (state_q == ST_WB) ? da_q  : bus.LoadAddr;
  assign wdata   = (state_q == ST_WB) ? res_q : bus.LoadData;
  assign rb_addr = (state_q == ST_IDLE) ? instr_ba : ba_q;

  alu_sequencer_regfile #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_regfile (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (wdata),
    .ra_addr_i(instr_aa),
    .ra_data_o(rd_a),
    .rb_addr_i(rb_addr),
    .rb_data_o(rd_b),
    .rr_addr_i(bus.ReadAddr),
    .rr_data_o(bus.ReadData)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      fs_q    <= '0;
      da_q    <= '0;
      ba_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      alua_q  <= '0;
      alub_q  <= '0;
      alufs_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            fs_q  <= instr_fs;
            da_q  <= instr_da;
            ba_q  <= instr_ba;
            cnt_q <= instr_rep;
            if (fs_legal(instr_fs)) begin
              alua_q  <= rd_a;
              alub_q  <= rd_b;
              alufs_q <= instr_fs;
              state_q <= ST_EXEC;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          res_q   <= bus.AluResult;
          state_q <= ST_WB;
        end
        ST_WB: begin
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            // R[DA] is written on this same edge, so forward the result.
            cnt_q   <= cnt_q - 3'd1;
            alua_q  <= res_q;
            alub_q  <= (ba_q == da_q) ? res_q : rd_b;
            alufs_q <= fs_q;
            state_q <= ST_EXEC;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.InstrReady = ready;
  assign bus.AluA       = alua_q;
  assign bus.AluB       = alub_q;
  assign bus.AluFS      = alufs_q;
  assign bus.Done       = done_q;
  assign bus.Error      = err_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic zf_q;
  logic nf_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      zf_q <= 1'b0;
      nf_q <= 1'b0;
    end else if (state_q == ST_WB) begin
      zf_q <= (res_q == '0);
      nf_q <= res_q[DATA_W-1];
    end
  end

  assign bus.ZeroFlag = zf_q;
  assign bus.NegFlag  = nf_q;
`else
  assign bus.ZeroFlag = 1'b0;
  assign bus.NegFlag  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural FunctionUnit and a
// register-file model producing expected results and AluA sequences.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  typedef struct {
    logic [2:0]  da;
    logic [15:0] val;
    int          lat;
  } exp_t;

  logic Clk;
  logic Rst_n;
  int   checks;
  int   errors;

  logic [15:0] m [8];
  exp_t        exp_q [$];
  logic [15:0] alua_q [$];

  alu_sequencer_if #(.DATA_W(16), .REG_ADDR_W(3)) bus ();

  alu_sequencer #(.DATA_W(16), .REG_COUNT(8), .REG_ADDR_W(3)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] fu(input logic [15:0] a, input logic [15:0] b,
                                     input logic [3:0] fs);
    case (fs)
      FS_TSFA:  fu = a;
      FS_INC:   fu = a + 16'd1;
      FS_ADD:   fu = a + b;
      FS_ADDC:  fu = a + b + 16'd1;
      FS_ADDNB: fu = a + ~b;
      FS_SUB:   fu = a + ~b + 16'd1;
      FS_DEC:   fu = a - 16'd1;
      FS_TSFA2: fu = a;
      FS_AND:   fu = a & b;
      FS_OR:    fu = a | b;
      FS_XOR:   fu = a ^ b;
      FS_NOT:   fu = ~a;
      FS_TSFB:  fu = b;
      default:  fu = 16'h0000;
    endcase
  endfunction

  always_comb bus.AluResult = fu(bus.AluA, bus.AluB, bus.AluFS);

  function automatic logic [15:0] mk(input logic [3:0] fs, input logic [2:0] da,
                                     input logic [2:0] aa, input logic [2:0] ba,
                                     input logic [2:0] rep);
    return {fs, da, aa, ba, rep};
  endfunction

  task automatic expect_instr(input logic [3:0] fs, input logic [2:0] da, input logic [2:0] aa,
                              input logic [2:0] ba, input logic [2:0] rep);
    exp_t        e;
    logic [15:0] a;
    if (fs > FS_LAST) return;
    for (int i = 0; i <= int'(rep); i++) begin
      a = (i == 0) ? m[aa] : m[da];
      alua_q.push_back(a);
      m[da] = fu(a, m[ba], fs);
    end
    e.da  = da;
    e.val = m[da];
    e.lat = 2 * (int'(rep) + 1);
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [2:0] addr, input logic [15:0] data);
    @(negedge Clk);
    bus.LoadEn = 1'b1; bus.LoadAddr = addr; bus.LoadData = data;
    m[addr] = data;
    @(negedge Clk);
    bus.LoadEn = 1'b0;
  endtask

  // Drives from the current negedge; returns at the negedge after the accept edge.
  task automatic drive_now(input logic [3:0] fs, input logic [2:0] da, input logic [2:0] aa,
                           input logic [2:0] ba, input logic [2:0] rep);
    bus.InstrValid = 1'b1;
    bus.Instr      = mk(fs, da, aa, ba, rep);
    #1;
    checks++;
    if (bus.InstrReady !== 1'b1) begin
      errors++;
      $display("FAIL ready_at_issue: got %b want 1", bus.InstrReady);
    end
    expect_instr(fs, da, aa, ba, rep);
    @(posedge Clk);
    @(negedge Clk);
    bus.InstrValid = 1'b0;
  endtask

  task automatic issue(input logic [3:0] fs, input logic [2:0] da, input logic [2:0] aa,
                       input logic [2:0] ba, input logic [2:0] rep);
    @(negedge Clk);
    drive_now(fs, da, aa, ba, rep);
  endtask

  task automatic wait_done(input bit ld_in_exec);
    exp_t        e;
    logic [15:0] ea;
    int          lat;
    bit          seen;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries want 1");
      return;
    end
    e = exp_q.pop_front();
    lat = 0;
    seen = 1'b0;
    for (int k = 0; k <= 60 && !seen; k++) begin
      if (k > 0) begin
        @(posedge Clk);
        @(negedge Clk);
      end
      if (ld_in_exec && k == 0) begin
        bus.LoadEn = 1'b1; bus.LoadAddr = 3'd0; bus.LoadData = 16'hBEEF;
      end else if (ld_in_exec && k == 1) begin
        bus.LoadEn = 1'b0;
      end
      if (bus.Done === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end else if ((k % 2) == 0 && alua_q.size() > 0) begin
        ea = alua_q.pop_front();
        checks++;
        if (bus.AluA !== ea) begin
          errors++;
          $display("FAIL alu_a_iter%0d: got %h want %h", k / 2, bus.AluA, ea);
        end
      end
    end
    alua_q.delete();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no Done want Done after %0d cycles", e.lat);
      return;
    end
    if (lat != e.lat) begin
      errors++;
      $display("FAIL done_latency: got %0d want %0d", lat, e.lat);
    end
    bus.ReadAddr = e.da;
    #1;
    checks++;
    if (bus.ReadData !== e.val) begin
      errors++;
      $display("FAIL result_R%0d: got %h want %h", e.da, bus.ReadData, e.val);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int r = 0; r < 8; r++) begin
      bus.ReadAddr = 3'(r);
      #1;
      checks++;
      if (bus.ReadData !== m[r]) begin
        errors++;
        $display("FAIL %s_R%0d: got %h want %h", tag, r, bus.ReadData, m[r]);
      end
    end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    bus.InstrValid = 1'b0; bus.Instr = '0; bus.LoadEn = 1'b0;
    bus.LoadAddr = '0; bus.LoadData = '0; bus.ReadAddr = '0;
    for (int r = 0; r < 8; r++) m[r] = 16'h0000;
    repeat (3) @(negedge Clk);
    checks++;
    if ({bus.Done, bus.Error, bus.ZeroFlag, bus.NegFlag} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses: got %b want 0000",
               {bus.Done, bus.Error, bus.ZeroFlag, bus.NegFlag});
    end
    checks++;
    if ({bus.AluA, bus.AluB, bus.AluFS} !== 36'h0) begin
      errors++;
      $display("FAIL reset_alu_out: got %h want 0", {bus.AluA, bus.AluB, bus.AluFS});
    end
    Rst_n = 1'b1;
    @(negedge Clk);
    checks++;
    if (bus.InstrReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", bus.InstrReady);
    end
    check_regs("reset");
  endtask

  task automatic test_basic_add;
    load(3'd1, 16'd5);
    load(3'd2, 16'd3);
    issue(FS_ADD, 3'd3, 3'd1, 3'd2, 3'd0);
    wait_done(1'b0);
    bus.ReadAddr = 3'd3;
    #1;
    checks++;
    if (bus.ReadData !== 16'd8) begin
      errors++;
      $display("FAIL add_R3_literal: got %h want 0008", bus.ReadData);
    end
    @(posedge Clk);
    @(negedge Clk);
    checks++;
    if (bus.Done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: got %b want 0", bus.Done);
    end
  endtask

  task automatic test_repeat_inc;
    issue(FS_INC, 3'd4, 3'd1, 3'd0, 3'd3);
    wait_done(1'b0);
    bus.ReadAddr = 3'd4;
    #1;
    checks++;
    if (bus.ReadData !== 16'd9) begin
      errors++;
      $display("FAIL inc_R4_literal: got %h want 0009", bus.ReadData);
    end
  endtask

  task automatic test_illegal_fs;
    issue(4'b1110, 3'd2, 3'd1, 3'd1, 3'd0);
    checks++;
    if ({bus.Error, bus.Done} !== 2'b10) begin
      errors++;
      $display("FAIL illegal_error: got Error=%b Done=%b want 1/0", bus.Error, bus.Done);
    end
    @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({bus.Error, bus.Done, bus.InstrReady} !== 3'b001) begin
      errors++;
      $display("FAIL illegal_after: got %b want 001", {bus.Error, bus.Done, bus.InstrReady});
    end
    check_regs("illegal");
  endtask

  task automatic test_flags;
    logic ez;
    logic en;
    load(3'd1, 16'd7);
    issue(FS_SUB, 3'd5, 3'd1, 3'd1, 3'd0);
    wait_done(1'b0);
`ifdef ALU_SEQ_FLAGS_EN
    ez = (m[5] == 16'h0000); en = m[5][15];
`else
    ez = 1'b0; en = 1'b0;
`endif
    checks++;
    if ({bus.ZeroFlag, bus.NegFlag} !== {ez, en}) begin
      errors++;
      $display("FAIL flags_zero: got %b%b want %b%b", bus.ZeroFlag, bus.NegFlag, ez, en);
    end
    issue(FS_DEC, 3'd6, 3'd5, 3'd0, 3'd0);
    wait_done(1'b0);
`ifdef ALU_SEQ_FLAGS_EN
    ez = (m[6] == 16'h0000); en = m[6][15];
`else
    ez = 1'b0; en = 1'b0;
`endif
    checks++;
    if ({bus.ZeroFlag, bus.NegFlag} !== {ez, en}) begin
      errors++;
      $display("FAIL flags_neg: got %b%b want %b%b", bus.ZeroFlag, bus.NegFlag, ez, en);
    end
    bus.ReadAddr = 3'd6;
    #1;
    checks++;
    if (bus.ReadData !== 16'hFFFF) begin
      errors++;
      $display("FAIL dec_R6_literal: got %h want ffff", bus.ReadData);
    end
  endtask

  task automatic test_load_priority;
    @(negedge Clk);
    bus.LoadEn = 1'b1; bus.LoadAddr = 3'd7; bus.LoadData = 16'h1234;
    bus.InstrValid = 1'b1; bus.Instr = mk(FS_ADD, 3'd2, 3'd7, 3'd1, 3'd0);
    m[7] = 16'h1234;
    #1;
    checks++;
    if (bus.InstrReady !== 1'b0) begin
      errors++;
      $display("FAIL ready_during_load: got %b want 0", bus.InstrReady);
    end
    @(negedge Clk);
    bus.LoadEn = 1'b0;
    drive_now(FS_ADD, 3'd2, 3'd7, 3'd1, 3'd0);
    wait_done(1'b1);
    check_regs("load_prio");
  endtask

  task automatic test_back_to_back;
    issue(FS_XOR, 3'd3, 3'd7, 3'd4, 3'd0);
    wait_done(1'b0);
    drive_now(FS_ADD, 3'd2, 3'd1, 3'd2, 3'd2);
    wait_done(1'b0);
    check_regs("b2b");
  endtask

  task automatic test_reset_mid_op;
    bit done_seen;
    load(3'd1, 16'd5);
    issue(FS_INC, 3'd4, 3'd1, 3'd0, 3'd3);
    repeat (2) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    Rst_n = 1'b0;
    for (int r = 0; r < 8; r++) m[r] = 16'h0000;
    exp_q.delete();
    alua_q.delete();
    #1;
    checks++;
    if ({bus.Done, bus.AluA} !== 17'h0) begin
      errors++;
      $display("FAIL midreset_out: got %h want 0", {bus.Done, bus.AluA});
    end
    check_regs("midreset");
    @(negedge Clk);
    Rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (bus.Done === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (done_seen) begin
      errors++;
      $display("FAIL midreset_no_done: got Done=1 want 0");
    end
    load(3'd2, 16'h0010);
    load(3'd3, 16'h0003);
    issue(FS_ADD, 3'd1, 3'd2, 3'd3, 3'd1);
    wait_done(1'b0);
    check_regs("post_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_add();
    test_repeat_inc();
    test_illegal_fs();
    test_flags();
    test_load_priority();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
